// File: rtl/if_fetch_pkg.sv
// Shared state encodings, bus widths and helpers for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        IF_FETCH   = 2'd0,
        IF_WAIT    = 2'd1,
        IF_DISCARD = 2'd2
    } if_state_t;

    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache of one-word lines: combinational lookup, fill on a completed memory fetch.
// Lookup is same-cycle; fills land at the next edge and are frozen while rdy is low.
module if_icache
    import if_fetch_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [29:0]       addr,
    input  logic              fill,
    input  logic [INST_W-1:0] fill_data,
    output logic              hit,
    output logic [INST_W-1:0] rdata
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [INST_W-1:0] data_mem [LINES];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  line_vld;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;

    assign idx   = addr[IDX_W-1:0];
    assign tag   = addr[29:IDX_W];
    assign hit   = line_vld[idx] && (tag_mem[idx] == tag);
    assign rdata = data_mem[idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            line_vld <= '0;
        end else if (rdy && fill) begin
            line_vld[idx] <= 1'b1;
        end
    end

    // Payload arrays need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (rdy && fill) begin
            data_mem[idx] <= fill_data;
            tag_mem[idx]  <= tag;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, fetches one word per instruction, presents if_pc/if_inst to IF_ID; optional I-cache via IF_FETCH_ICACHE_EN.
// Latency: memory latency + 1 cycle per instruction (1 cycle on a cache hit); redirect takes effect at the next edge.
// Backpressure: stall[1] holds the presented instruction; rdy low freezes every register; stall_req flags no valid instruction.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [4:0]  stall,
    input  logic        id_use_npc,
    input  logic [31:0] id_npc_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stall_req
);

    if_state_t             state;
    logic [INST_ADDR_W-1:0] pc;
    logic                  valid;

    logic              cache_hit;
    logic [INST_W-1:0] cache_data;

    logic              req_open;
    logic              pending;
    logic              redirect;
    logic              consume;
    logic              mem_fill;
    logic              got;
    logic [INST_W-1:0] got_data;
    logic              unused_bits;

    // A request is open while fetching without a hit, or waiting without a word yet.
    assign req_open = ((state == IF_FETCH) && !cache_hit) || ((state == IF_WAIT) && !valid);
    assign pending  = req_open || (state == IF_DISCARD);
    assign redirect = id_use_npc && !stall[1];
    assign consume  = valid && !stall[1] && !id_use_npc;
    assign mem_fill = req_open && mem_done;
    assign got      = mem_fill || ((state == IF_FETCH) && cache_hit);
    assign got_data = cache_hit ? cache_data : mem_rdata;

    assign mem_req   = rst && req_open;
    assign mem_addr  = pc;
    assign stall_req = !rst || !valid || id_use_npc;

    assign unused_bits = ^{stall[4:2], stall[0]};

`ifdef IF_FETCH_ICACHE_EN
    logic lookup_hit;
    logic cache_fill;

    assign cache_fill = rst && mem_fill && !redirect;
    assign cache_hit  = lookup_hit && (state == IF_FETCH);

    if_icache #(
        .LINES (ICACHE_LINES)
    ) u_icache (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .addr      (pc[31:2]),
        .fill      (cache_fill),
        .fill_data (mem_rdata),
        .hit       (lookup_hit),
        .rdata     (cache_data)
    );
`else
    logic unused_icache_cfg;

    assign cache_hit         = 1'b0;
    assign cache_data        = ZERO_WORD;
    assign unused_icache_cfg = ^ICACHE_LINES;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc      <= word_align(RESET_PC);
            state   <= IF_FETCH;
            valid   <= 1'b0;
            if_pc   <= '0;
            if_inst <= ZERO_WORD;
        end else if (rdy) begin
            if (redirect) begin
                // A word still in flight must be drained before the new path is fetched.
                pc    <= word_align(id_npc_addr);
                valid <= 1'b0;
                state <= (pending && !mem_done) ? IF_DISCARD : IF_FETCH;
            end else if (consume) begin
                pc    <= pc + 32'd4;
                valid <= 1'b0;
                state <= IF_FETCH;
            end else begin
                case (state)
                    IF_FETCH: begin
                        if (got) begin
                            if_pc   <= pc;
                            if_inst <= got_data;
                            valid   <= 1'b1;
                        end
                        state <= IF_WAIT;
                    end
                    IF_WAIT: begin
                        if (got) begin
                            if_pc   <= pc;
                            if_inst <= got_data;
                            valid   <= 1'b1;
                        end
                    end
                    IF_DISCARD: begin
                        if (mem_done) begin
                            state <= IF_FETCH;
                        end
                    end
                    default: state <= IF_FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a fixed-latency word memory and a manual override for rdy tests.
module tb_if_fetch;

    localparam int MEM_LAT = 3;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [4:0]  stall;
    logic        id_use_npc;
    logic [31:0] id_npc_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stall_req;

    int n_vec = 0;
    int n_bad = 0;

    logic        mem_auto;
    logic        man_done;
    logic [31:0] man_rdata;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_rdata = '0;
    int          m_cnt = 0;
    int          req_count = 0;

    if_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .stall       (stall),
        .id_use_npc  (id_use_npc),
        .id_npc_addr (id_npc_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .stall_req   (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_done  = mem_auto ? m_done : man_done;
    assign mem_rdata = mem_auto ? m_rdata : man_rdata;

    // Memory word at address a is {16'hDEAD, a[15:0]}; done arrives MEM_LAT cycles after the request cycle.
    always @(posedge clk) begin
        if (!mem_auto) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_done  <= 1'b1;
                m_rdata <= {16'hDEAD, m_addr[15:0]};
            end
            m_cnt <= m_cnt - 1;
        end else if (mem_req && rdy) begin
            m_busy    <= 1'b1;
            m_addr    <= mem_addr;
            m_cnt     <= MEM_LAT - 1;
            req_count <= req_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (stall_req === 1'b0) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic wait_mem_req(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (mem_req === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic auto_mem);
        rst         = 1'b0;
        rdy         = 1'b1;
        stall       = 5'b0;
        id_use_npc  = 1'b0;
        id_npc_addr = '0;
        man_done    = 1'b0;
        man_rdata   = '0;
        mem_auto    = 1'b0;
        tick();
        tick();
        mem_auto = auto_mem;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        n_vec++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL reset_if_pc got %h want %h", if_pc, 32'h0); end
        n_vec++; if (if_inst !== 32'h0) begin n_bad++; $display("FAIL reset_if_inst got %h want %h", if_inst, 32'h0); end
        n_vec++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        n_vec++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL reset_stall_req got %b want 1", stall_req); end
        rst = 1'b1;
        #1;
        n_vec++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL first_mem_req got %b want 1", mem_req); end
        n_vec++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL first_mem_addr got %h want %h", mem_addr, 32'h0); end
    endtask

    task automatic test_sequential();
        int cyc;
        wait_valid(20, cyc);
        n_vec++; if (cyc !== 4) begin n_bad++; $display("FAIL seq0_latency got %0d want 4", cyc); end
        n_vec++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL seq0_pc got %h want %h", if_pc, 32'h0); end
        n_vec++; if (if_inst !== 32'hDEAD0000) begin n_bad++; $display("FAIL seq0_inst got %h want %h", if_inst, 32'hDEAD0000); end
        n_vec++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL seq0_req_drop got %b want 0", mem_req); end
        tick();
        n_vec++; if (mem_addr !== 32'h4) begin n_bad++; $display("FAIL seq1_addr got %h want %h", mem_addr, 32'h4); end
        n_vec++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL seq1_stall_req got %b want 1", stall_req); end
        wait_valid(20, cyc);
        n_vec++; if (cyc !== 4) begin n_bad++; $display("FAIL seq1_latency got %0d want 4", cyc); end
        n_vec++; if (if_inst !== 32'hDEAD0004) begin n_bad++; $display("FAIL seq1_inst got %h want %h", if_inst, 32'hDEAD0004); end
        tick();
        n_vec++; if (mem_addr !== 32'h8) begin n_bad++; $display("FAIL seq2_addr got %h want %h", mem_addr, 32'h8); end
        wait_valid(20, cyc);
        n_vec++; if (if_pc !== 32'h8) begin n_bad++; $display("FAIL seq2_pc got %h want %h", if_pc, 32'h8); end
    endtask

    task automatic test_stall_hold();
        int base;
        stall = 5'b00010;
        base  = req_count;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (if_pc !== 32'h8 || if_inst !== 32'hDEAD0008) begin n_bad++; $display("FAIL hold_out[%0d] got %h/%h want %h/%h", i, if_pc, if_inst, 32'h8, 32'hDEAD0008); end
            n_vec++; if (mem_req !== 1'b0 || mem_addr !== 32'h8) begin n_bad++; $display("FAIL hold_req[%0d] got %b/%h want 0/%h", i, mem_req, mem_addr, 32'h8); end
        end
        stall = 5'b0;
        tick();
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'hC) begin n_bad++; $display("FAIL hold_release got %b/%h want 1/%h", mem_req, mem_addr, 32'hC); end
        n_vec++; if (req_count !== base) begin n_bad++; $display("FAIL hold_no_req got %0d want %0d", req_count, base); end
    endtask

    task automatic test_redirect_wait();
        int cyc;
        tick();
        id_use_npc  = 1'b1;
        id_npc_addr = 32'h100;
        #1;
        n_vec++; if (stall_req !== 1'b1 || mem_req !== 1'b1) begin n_bad++; $display("FAIL rdw_cycle got %b/%b want 1/1", stall_req, mem_req); end
        tick();
        id_use_npc = 1'b0;
        n_vec++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rdw_discard_req got %b want 0", mem_req); end
        wait_mem_req(20, cyc);
        n_vec++; if (cyc !== 2) begin n_bad++; $display("FAIL rdw_discard_len got %0d want 2", cyc); end
        n_vec++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL rdw_new_addr got %h want %h", mem_addr, 32'h100); end
        wait_valid(20, cyc);
        n_vec++; if (if_pc !== 32'h100 || if_inst !== 32'hDEAD0100) begin n_bad++; $display("FAIL rdw_word got %h/%h want %h/%h", if_pc, if_inst, 32'h100, 32'hDEAD0100); end
    endtask

    task automatic test_redirect_done();
        int cyc;
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (mem_done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        n_vec++; if (cyc < 0) begin n_bad++; $display("FAIL rdd_done_timeout got %0d want >0", cyc); end
        id_use_npc  = 1'b1;
        id_npc_addr = 32'h203;
        tick();
        id_use_npc = 1'b0;
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin n_bad++; $display("FAIL rdd_fetch got %b/%h want 1/%h", mem_req, mem_addr, 32'h200); end
        n_vec++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL rdd_dropped got %b want 1", stall_req); end
        wait_valid(20, cyc);
        n_vec++; if (cyc !== 4) begin n_bad++; $display("FAIL rdd_latency got %0d want 4", cyc); end
        n_vec++; if (if_pc !== 32'h200 || if_inst !== 32'hDEAD0200) begin n_bad++; $display("FAIL rdd_word got %h/%h want %h/%h", if_pc, if_inst, 32'h200, 32'hDEAD0200); end
        // Redirect while IF_ID is held is ignored.
        stall       = 5'b00010;
        id_use_npc  = 1'b1;
        id_npc_addr = 32'h300;
        #1;
        n_vec++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL rdh_stall_req got %b want 1", stall_req); end
        tick();
        id_use_npc = 1'b0;
        #1;
        n_vec++; if (stall_req !== 1'b0 || if_pc !== 32'h200) begin n_bad++; $display("FAIL rdh_ignored got %b/%h want 0/%h", stall_req, if_pc, 32'h200); end
        stall = 5'b0;
        tick();
        n_vec++; if (mem_addr !== 32'h204) begin n_bad++; $display("FAIL rdh_next got %h want %h", mem_addr, 32'h204); end
    endtask

    task automatic test_rdy_freeze();
        do_reset(1'b0);
        rst = 1'b1;
        tick();
        tick();
        rdy       = 1'b0;
        man_done  = 1'b1;
        man_rdata = 32'hCAFEF00D;
        tick();
        man_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (stall_req !== 1'b1 || if_inst !== 32'h0 || mem_req !== 1'b1) begin n_bad++; $display("FAIL rdy_frozen[%0d] got %b/%h/%b want 1/%h/1", i, stall_req, if_inst, mem_req, 32'h0); end
            tick();
        end
        rdy = 1'b1;
        tick();
        n_vec++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL rdy_missed_done got %b want 1", stall_req); end
        man_done  = 1'b1;
        man_rdata = 32'h12345678;
        tick();
        man_done = 1'b0;
        n_vec++; if (stall_req !== 1'b0 || if_inst !== 32'h12345678 || if_pc !== 32'h0) begin n_bad++; $display("FAIL rdy_accept got %b/%h/%h want 0/%h/%h", stall_req, if_inst, if_pc, 32'h12345678, 32'h0); end
        rdy = 1'b0;
        tick();
        n_vec++; if (stall_req !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL rdy_no_consume got %b/%b want 0/0", stall_req, mem_req); end
        rdy = 1'b1;
        tick();
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin n_bad++; $display("FAIL rdy_resume got %b/%h want 1/%h", mem_req, mem_addr, 32'h4); end
    endtask

    task automatic test_pc_wrap();
        int cyc;
        do_reset(1'b1);
        rst = 1'b1;
        wait_valid(20, cyc);
        id_use_npc  = 1'b1;
        id_npc_addr = 32'hFFFFFFFC;
        tick();
        id_use_npc = 1'b0;
        n_vec++; if (mem_addr !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL wrap_target got %h want %h", mem_addr, 32'hFFFFFFFC); end
        wait_valid(20, cyc);
        n_vec++; if (if_pc !== 32'hFFFFFFFC || if_inst !== 32'hDEADFFFC) begin n_bad++; $display("FAIL wrap_word got %h/%h want %h/%h", if_pc, if_inst, 32'hFFFFFFFC, 32'hDEADFFFC); end
        tick();
        n_vec++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_pc got %h want %h", mem_addr, 32'h0); end
    endtask

`ifdef IF_FETCH_ICACHE_EN
    task automatic test_icache_loop();
        int cyc;
        int base;
        logic [31:0] exp_pc;
        do_reset(1'b1);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(20, cyc);
            n_vec++; if (cyc !== (k == 0 ? 4 : 5)) begin n_bad++; $display("FAIL ic_miss_lat[%0d] got %0d want %0d", k, cyc, (k == 0 ? 4 : 5)); end
        end
        id_use_npc  = 1'b1;
        id_npc_addr = 32'h0;
        tick();
        id_use_npc = 1'b0;
        base = req_count;
        for (int k = 0; k < 3; k++) begin
            exp_pc = 32'(k * 4);
            n_vec++; if (mem_req !== 1'b0 || stall_req !== 1'b1 || mem_addr !== exp_pc) begin n_bad++; $display("FAIL ic_fetch[%0d] got %b/%b/%h want 0/1/%h", k, mem_req, stall_req, mem_addr, exp_pc); end
            tick();
            n_vec++; if (stall_req !== 1'b0 || if_pc !== exp_pc || if_inst !== {16'hDEAD, exp_pc[15:0]}) begin n_bad++; $display("FAIL ic_hit[%0d] got %b/%h/%h want 0/%h/%h", k, stall_req, if_pc, if_inst, exp_pc, {16'hDEAD, exp_pc[15:0]}); end
            if (k == 2) begin
                id_use_npc = 1'b1;
            end
            tick();
            id_use_npc = 1'b0;
        end
        n_vec++; if (req_count !== base) begin n_bad++; $display("FAIL ic_no_mem got %0d want %0d", req_count, base); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_done();
        test_rdy_freeze();
        test_pc_wrap();
`ifdef IF_FETCH_ICACHE_EN
        test_icache_loop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
